present_dec: RTL

- Iterative PRESENT-128 decryption core. It is the inverse of the existing PRESENT encryption accelerator.
- Recovers a 64-bit plaintext from a 64-bit ciphertext under a 128-bit key.
- Sits beside the encryption core behind the same Avalon accelerator wrapper and uses the same start/eoc handshake.
- Runs the key schedule forward to the final round key, then unrolls the rounds backwards at one round per cycle. A last-key cache skips the forward expansion when the key is reused.

---
 rtl/present_pkg.sv | 66 ++++++
 rtl/present_dec_ks.sv | 59 +++++
 rtl/present_dec.sv | 96 +++++++++
 3 files changed

// File: rtl/present_pkg.sv
// Shared PRESENT definitions: S-box tables, layer functions and 128-bit key schedule steps.
// Used by both the encryption and decryption cores.
package present_pkg;

  localparam int ROUNDS = 31;

  // Nibble x of each table holds S[x] / S^-1[x].
  localparam logic [63:0] SBOX     = 64'h21748FE3DA09B65C;
  localparam logic [63:0] INV_SBOX = 64'hA970364BD21C8FE5;

  typedef enum logic [1:0] {IDLE, EXPAND, DECRYPT, DONE} state_t;

  function automatic logic [3:0] sbox4(input logic [3:0] x);
    return SBOX[{x, 2'b00} +: 4];
  endfunction

  function automatic logic [3:0] inv_sbox4(input logic [3:0] x);
    return INV_SBOX[{x, 2'b00} +: 4];
  endfunction

  function automatic logic [63:0] sbox_layer(input logic [63:0] s);
    logic [63:0] o;
    for (int n = 0; n < 16; n++) o[4*n +: 4] = sbox4(s[4*n +: 4]);
    return o;
  endfunction

  function automatic logic [63:0] inv_sbox_layer(input logic [63:0] s);
    logic [63:0] o;
    for (int n = 0; n < 16; n++) o[4*n +: 4] = inv_sbox4(s[4*n +: 4]);
    return o;
  endfunction

  // Bit j moves to 16*j mod 63; bit 63 stays in place.
  function automatic logic [63:0] p_layer(input logic [63:0] s);
    logic [63:0] o;
    o = s;
    for (int j = 0; j < 63; j++) o[6'((16 * j) % 63)] = s[6'(j)];
    return o;
  endfunction

  function automatic logic [63:0] inv_p_layer(input logic [63:0] s);
    logic [63:0] o;
    o = s;
    for (int j = 0; j < 63; j++) o[6'(j)] = s[6'((16 * j) % 63)];
    return o;
  endfunction

  function automatic logic [127:0] key_fwd(input logic [127:0] k, input logic [4:0] i);
    logic [127:0] r;
    r = {k[66:0], k[127:67]};
    r[127:124] = sbox4(r[127:124]);
    r[123:120] = sbox4(r[123:120]);
    r[66:62]   = r[66:62] ^ i;
    return r;
  endfunction

  function automatic logic [127:0] key_inv(input logic [127:0] k, input logic [4:0] i);
    logic [127:0] r;
    r = k;
    r[66:62]   = r[66:62] ^ i;
    r[127:124] = inv_sbox4(r[127:124]);
    r[123:120] = inv_sbox4(r[123:120]);
    return {r[60:0], r[127:61]};
  endfunction

endpackage

// File: rtl/present_dec_ks.sv
// Key register for the decryption core: forward expansion to K32, backward unwinding,
// and a one-entry cache of the last expanded key.
module present_dec_ks #(
  parameter int KEY_CACHE = 1,
  parameter int ROUNDS    = 31
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic         load,
  input  logic [127:0] key,
  input  logic         step_fwd,
  input  logic         step_inv,
  input  logic [4:0]   cnt,
  output logic         hit,
  output logic [63:0]  rk
);
  import present_pkg::*;

  logic [127:0] k;
  logic [127:0] k_next;
  logic [127:0] cache_key;
  logic [127:0] cache_k32;
  logic         cache_valid;

  assign hit = (KEY_CACHE != 0) && cache_valid && (key == cache_key);

  // Outside a stepping state the exported round key is the cached K32, used on a hit.
  always_comb begin
    k_next = cache_k32;
    if (step_fwd)      k_next = key_fwd(k, cnt);
    else if (step_inv) k_next = key_inv(k, cnt);
  end

  assign rk = k_next[127:64];

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      k           <= '0;
      cache_key   <= '0;
      cache_k32   <= '0;
      cache_valid <= 1'b0;
    end else if (load) begin
      k <= hit ? cache_k32 : key;
      if (!hit) begin
        cache_key   <= key;
        cache_valid <= 1'b0;
      end
    end else if (step_fwd) begin
      k <= k_next;
      if (cnt == 5'(ROUNDS)) begin
        cache_k32   <= k_next;
        cache_valid <= (KEY_CACHE != 0);
      end
    end else if (step_inv) begin
      k <= k_next;
    end
  end

endmodule

// File: rtl/present_dec.sv
// Iterative PRESENT-128 decryption core: expands the key to K32 (or takes it from the cache),
// then peels off one round per cycle.
module present_dec #(
  parameter int KEY_CACHE = 1,
  parameter int ROUNDS    = 31
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic         start,
  input  logic [63:0]  ciphertext,
  input  logic [127:0] key,
  output logic         eoc,
  output logic [63:0]  plaintext,
  output logic         busy
);
  import present_pkg::*;

  state_t      state;
  logic [4:0]  cnt;
  logic [63:0] d;
  logic [63:0] ct_r;
  logic [63:0] rk;
  logic [63:0] dround;
  logic        hit;
  logic        load;

  assign load   = start && (state == IDLE || state == DONE);
  assign dround = inv_sbox_layer(inv_p_layer(d)) ^ rk;

  present_dec_ks #(
    .KEY_CACHE (KEY_CACHE),
    .ROUNDS    (ROUNDS)
  ) u_ks (
    .clk      (clk),
    .nrst     (nrst),
    .load     (load),
    .key      (key),
    .step_fwd (state == EXPAND),
    .step_inv (state == DECRYPT),
    .cnt      (cnt),
    .hit      (hit),
    .rk       (rk)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state     <= IDLE;
      cnt       <= '0;
      d         <= '0;
      ct_r      <= '0;
      plaintext <= '0;
      eoc       <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            ct_r <= ciphertext;
            eoc  <= 1'b0;
            busy <= 1'b1;
            if (hit) begin
              d     <= ciphertext ^ rk;
              cnt   <= 5'(ROUNDS);
              state <= DECRYPT;
            end else begin
              cnt   <= 5'd1;
              state <= EXPAND;
            end
          end
        end
        // The last expansion step yields K32, which whitens the ciphertext directly.
        EXPAND: begin
          if (cnt == 5'(ROUNDS)) begin
            d     <= ct_r ^ rk;
            state <= DECRYPT;
          end else begin
            cnt <= cnt + 5'd1;
          end
        end
        DECRYPT: begin
          d <= dround;
          if (cnt == 5'd1) begin
            plaintext <= dround;
            eoc       <= 1'b1;
            busy      <= 1'b0;
            state     <= DONE;
          end else begin
            cnt <= cnt - 5'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
